// File: rtl/aes128_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes128_round_ctrl_if
// Block-level bus between a host and the iterative AES-128 sequencer.
//   in_valid / in_ready : plaintext+key offer handshake (host -> engine)
//   in_pt, in_key       : 128-bit plaintext and cipher key, column-major,
//                         byte s00 in [127:120]
//   key_reuse           : request to encrypt with the held key
//   out_valid/out_ready : ciphertext handshake (engine -> host)
//   out_ct              : 128-bit ciphertext, column-major
//   busy                : engine is computing or holding a result
// Modports: master = host side, slave = engine side.
// ---------------------------------------------------------------------------
interface aes128_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_pt;
  logic [127:0] in_key;
  logic         key_reuse;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ct;
  logic         busy;

  modport master (
    output in_valid, in_pt, in_key, key_reuse, out_ready,
    input  in_ready, out_valid, out_ct, busy
  );

  modport slave (
    input  in_valid, in_pt, in_key, key_reuse, out_ready,
    output in_ready, out_valid, out_ct, busy
  );
endinterface

// File: rtl/aes128_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes128_round_ctrl
// Iterative AES-128 encryption engine: one round datapath (SubBytes,
// ShiftRows, MixColumns, AddRoundKey and on-the-fly key expansion) reused
// for NR rounds at one round per clock.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   abort  : (only with AES_CTRL_ABORT_EN) drop the block in ROUND/DONE
//   bus    : aes128_round_ctrl_if.slave (input/output handshakes, busy)
//
// Parameters:
//   NR       : number of rounds (10 for AES-128; 4-bit round counter)
//   KEY_HOLD : 1 = keep the accepted cipher key so key_reuse=1 can use it
//
// Optional feature macro: AES_CTRL_ABORT_EN adds the abort input.
// ---------------------------------------------------------------------------
module aes128_round_ctrl #(
  parameter int NR       = 10,
  parameter bit KEY_HOLD = 1'b0
) (
  input logic clk,
  input logic rst_n,
`ifdef AES_CTRL_ABORT_EN
  input logic abort,
`endif
  aes128_round_ctrl_if.slave bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  // ---------------------------------------------------------------------
  // GF(2^8) helpers
  // ---------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box computed as affine(x^254); x^254 is the field inverse and maps
  // 0 to 0, so no special case is needed.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    inv = 8'h01;
    p   = x;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  fsm_t         fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;         // AES state
  logic [127:0] rk_q, rk_d;           // current round key
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic [127:0] out_ct_q, out_ct_d;
  logic [127:0] held_key_q, held_key_d;

  // ---------------------------------------------------------------------
  // Round datapath
  // ---------------------------------------------------------------------
  logic [127:0] sr_w;        // SubBytes followed by ShiftRows
  logic [127:0] mc_w;        // MixColumns(sr_w)
  logic [31:0]  w3_rot;
  logic [31:0]  sub_w;
  logic [31:0]  k_t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] rk_next;
  logic [127:0] round_out;
  logic         last_round;
  logic [127:0] key0;

  genvar gi;
  generate
    // Byte gi sits at row gi%4, column gi/4; ShiftRows pulls it from
    // column (c+r)%4 of the same row, so the S-box reads that byte directly.
    for (gi = 0; gi < 16; gi++) begin : g_sub_shift
      localparam int R   = gi % 4;
      localparam int C   = gi / 4;
      localparam int SRC = R + 4 * ((C + R) % 4);
      assign sr_w[127-8*gi -: 8] = sbox(blk_q[127-8*SRC -: 8]);
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr_w[127-32*gi -: 8];
      assign a1 = sr_w[119-32*gi -: 8];
      assign a2 = sr_w[111-32*gi -: 8];
      assign a3 = sr_w[103-32*gi -: 8];
      assign mc_w[127-32*gi -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end

    // SubWord(RotWord(w3)) for the key schedule
    for (gi = 0; gi < 4; gi++) begin : g_sub_word
      assign sub_w[31-8*gi -: 8] = sbox(w3_rot[31-8*gi -: 8]);
    end
  endgenerate

  assign w3_rot     = {rk_q[23:0], rk_q[31:24]};
  assign k_t        = sub_w ^ {rcon(round_ctr_q), 24'h000000};
  assign n0         = rk_q[127:96] ^ k_t;
  assign n1         = rk_q[95:64]  ^ n0;
  assign n2         = rk_q[63:32]  ^ n1;
  assign n3         = rk_q[31:0]   ^ n2;
  assign rk_next    = {n0, n1, n2, n3};
  assign last_round = (round_ctr_q == LAST_ROUND);
  // The final round skips MixColumns.
  assign round_out  = (last_round ? sr_w : mc_w) ^ rk_next;

  // Held key only substitutes when the hold option exists and is requested.
  assign key0 = (KEY_HOLD && bus.key_reuse) ? held_key_q : bus.in_key;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    fsm_d       = fsm_q;
    blk_d       = blk_q;
    rk_d        = rk_q;
    round_ctr_d = round_ctr_q;
    out_ct_d    = out_ct_q;
    held_key_d  = held_key_q;

    case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          blk_d       = bus.in_pt ^ key0;
          rk_d        = key0;
          round_ctr_d = 4'd1;
          if (KEY_HOLD) held_key_d = key0;
          fsm_d       = ROUND;
        end
      end
      ROUND: begin
        blk_d = round_out;
        rk_d  = rk_next;
        if (last_round) begin
          out_ct_d = round_out;
          fsm_d    = DONE;
        end else begin
          round_ctr_d = round_ctr_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          round_ctr_d = 4'd0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase

`ifdef AES_CTRL_ABORT_EN
    // Abort wins over everything, including the output handshake; the
    // visible ciphertext register is left as it was.
    if (abort && (fsm_q != IDLE)) begin
      fsm_d       = IDLE;
      blk_d       = blk_q;
      rk_d        = rk_q;
      round_ctr_d = 4'd0;
      out_ct_d    = out_ct_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      blk_q       <= '0;
      rk_q        <= '0;
      round_ctr_q <= 4'd0;
      out_ct_q    <= '0;
      held_key_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      blk_q       <= blk_d;
      rk_q        <= rk_d;
      round_ctr_q <= round_ctr_d;
      out_ct_q    <= out_ct_d;
      held_key_q  <= held_key_d;
    end
  end

  // Handshake outputs are decoded from the state register so that reset
  // drives them to their idle values immediately.
  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.busy      = (fsm_q != IDLE);
  assign bus.out_ct    = out_ct_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
module tb_aes128_round_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef AES_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  aes128_round_ctrl_if bus();

  aes128_round_ctrl #(.NR(10), .KEY_HOLD(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AES_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic [7:0]   sbox_t [256];
  logic [127:0] held_key = '0;   // model of the key the engine keeps
  logic [127:0] used_key;
  logic [127:0] last_ct;
  logic [127:0] rpt, rkey;
  bit           rreuse;
  bit           seen;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc = 8'h01;
    logic [127:0] res;
    for (int k = 0; k < 4; k++) w[k] = key[127-32*k -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox_t[s[(k%4) + 4*(((k/4) + (k%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
          s[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int k = 0; k < 16; k++) s[k] ^= w[4*rnd + k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checks ----------------
  task automatic check_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Offer a block at the current negedge; leaves us at the negedge after
  // the accepting edge with the inputs scrambled (or set to the next block).
  task automatic start(input logic [127:0] pt, input logic [127:0] key, input bit reuse,
                       input bit keep_valid, input logic [127:0] npt,
                       input logic [127:0] nkey, input string tag);
    check_b({tag, " in_ready_before"}, bus.in_ready, 1'b1);
    bus.in_valid  = 1'b1;
    bus.in_pt     = pt;
    bus.in_key    = key;
    bus.key_reuse = reuse;
    used_key = reuse ? held_key : key;
    held_key = used_key;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = keep_valid;
    bus.in_pt     = npt;
    bus.in_key    = nkey;
    bus.key_reuse = 1'($urandom_range(0, 1));
    check_b({tag, " busy_after_accept"}, bus.busy, 1'b1);
    check_b({tag, " in_ready_after_accept"}, bus.in_ready, 1'b0);
    $display("accept %s pt=%h key=%h reuse=%0b", tag, pt, key, reuse);
  endtask

  task automatic finish(input logic [127:0] exp, input int hold, input string tag);
    int lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_w({tag, " latency"}, 128'(lat), 128'd10);
    for (int i = 0; i < hold; i++) begin
      check_w({tag, " ct_hold"}, bus.out_ct, exp);
      check_b({tag, " valid_hold"}, bus.out_valid, 1'b1);
      check_b({tag, " in_ready_hold"}, bus.in_ready, 1'b0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check_b({tag, " out_valid"}, bus.out_valid, 1'b1);
    check_w({tag, " out_ct"}, bus.out_ct, exp);
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_b({tag, " valid_cleared"}, bus.out_valid, 1'b0);
    check_b({tag, " in_ready_back"}, bus.in_ready, 1'b1);
    check_b({tag, " busy_cleared"}, bus.busy, 1'b0);
    last_ct = exp;
    $display("output %s ct=%h latency=%0d hold=%0d", tag, bus.out_ct, lat, hold);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pt     = '0;
    bus.in_key    = '0;
    bus.key_reuse = 1'b0;
    bus.out_ready = 1'b0;
    build_sbox();

    // Reset state
    #1;
    check_b("reset in_ready", bus.in_ready, 1'b1);
    check_b("reset out_valid", bus.out_valid, 1'b0);
    check_b("reset busy", bus.busy, 1'b0);
    check_w("reset out_ct", bus.out_ct, 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // key_reuse before any key loaded: all-zero key
    rpt = rand128();
    start(rpt, rand128(), 1'b1, 1'b0, rand128(), rand128(), "zero_key");
    finish(aes_ref(128'h0, rpt), 1, "zero_key");

    // FIPS-197 C.1 and B (with 20 cycles of backpressure)
    start(V1_PT, V1_KEY, 1'b0, 1'b0, rand128(), rand128(), "fips_c1");
    finish(V1_CT, 0, "fips_c1");
    start(V2_PT, V2_KEY, 1'b0, 1'b0, rand128(), rand128(), "fips_b");
    finish(V2_CT, 20, "fips_b");

    // Back-to-back with in_valid held high
    start(V1_PT, V1_KEY, 1'b0, 1'b1, V2_PT, V2_KEY, "b2b_1");
    finish(V1_CT, 2, "b2b_1");
    start(V2_PT, V2_KEY, 1'b0, 1'b0, rand128(), rand128(), "b2b_2");
    finish(V2_CT, 0, "b2b_2");

    // Key hold: reuse the vector-2 key with a zero in_key
    start(V1_PT, 128'h0, 1'b1, 1'b0, rand128(), rand128(), "key_reuse");
    finish(aes_ref(V2_KEY, V1_PT), 0, "key_reuse");

    // Randomized blocks against the model
    for (int n = 0; n < 8; n++) begin
      rpt    = rand128();
      rkey   = rand128();
      rreuse = 1'($urandom_range(0, 1));
      start(rpt, rkey, rreuse, 1'b0, rand128(), rand128(), "random");
      finish(aes_ref(used_key, rpt), int'($urandom_range(0, 3)), "random");
    end

    // Asynchronous reset during round 5
    start(V1_PT, V1_KEY, 1'b0, 1'b0, rand128(), rand128(), "mid_reset");
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    held_key = '0;
    #1;
    check_b("mid_reset in_ready", bus.in_ready, 1'b1);
    check_b("mid_reset out_valid", bus.out_valid, 1'b0);
    check_b("mid_reset busy", bus.busy, 1'b0);
    check_w("mid_reset out_ct", bus.out_ct, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check_b("mid_reset no_output", seen, 1'b0);
    $display("reset mid-round done");
    start(V1_PT, V1_KEY, 1'b0, 1'b0, rand128(), rand128(), "after_reset");
    finish(V1_CT, 0, "after_reset");

`ifdef AES_CTRL_ABORT_EN
    // Abort during round 3
    start(V2_PT, V2_KEY, 1'b0, 1'b0, rand128(), rand128(), "abort");
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check_b("abort in_ready", bus.in_ready, 1'b1);
    check_b("abort busy", bus.busy, 1'b0);
    check_w("abort out_ct_kept", bus.out_ct, last_ct);
    seen = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check_b("abort no_output", seen, 1'b0);
    $display("abort at round 3 done");
    start(V1_PT, V1_KEY, 1'b0, 1'b0, rand128(), rand128(), "after_abort");
    finish(V1_CT, 0, "after_abort");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
